// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared bus widths and arbiter FSM state encoding
package mem_bus_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: native valid/ready memory bus; master drives valid/addr/wdata/wstrb, slave returns ready/rdata
interface mem_bus_arbiter_if import mem_bus_arbiter_pkg::*; ();
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// rr_pick2: 2-way chooser; req[1:0], last winner, mode (1 = fixed req[0] priority) in, one-hot win out
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       mode,
  output logic [1:0] win
);
  logic p0;
  always_comb begin
    p0  = req[0] & (~req[1] | mode | last);
    win = {req[1] & ~p0, p0};
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master bus arbiter with watchdog; clk/reset, m0/m1 master buses, s downstream bus, grant, timeout_err
module mem_bus_arbiter import mem_bus_arbiter_pkg::*; #(
  parameter int                PRIORITY_MODE = 0,
  parameter int                TIMEOUT       = 255,
  parameter logic [DATA_W-1:0] ERR_DATA      = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.slave  m0,
  mem_bus_arbiter_if.slave  m1,
  mem_bus_arbiter_if.master s,
  output logic [1:0]        grant,
  output logic              timeout_err
);
  localparam int WDOG_W = ($clog2(TIMEOUT) < 8) ? 8 : (($clog2(TIMEOUT) > 16) ? 16 : $clog2(TIMEOUT));
  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d, ready_q, ready_d, win;
  logic              last_q, last_d, terr_q, terr_d, busy, sel, mv;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d, rsp;
  rr_pick2 u_pick (
    .req  ({m1.valid, m0.valid}),
    .last (last_q),
    .mode (PRIORITY_MODE != 0),
    .win  (win)
  );
  always_comb begin
    busy    = (state_q == ST_BUSY0) || (state_q == ST_BUSY1);
    sel     = state_q == ST_BUSY1;
    mv      = sel ? m1.valid : m0.valid;
    s.valid = busy & mv;
    s.addr  = busy ? (sel ? m1.addr : m0.addr) : '0;
    s.wdata = busy ? (sel ? m1.wdata : m0.wdata) : '0;
    s.wstrb = busy ? (sel ? m1.wstrb : m0.wstrb) : '0;
    rsp     = s.ready ? s.rdata : ERR_DATA;
  end
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    wdog_d   = wdog_q;
    ready_d  = '0;
    terr_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (state_q == ST_IDLE) begin
      if (|win) begin
        state_d = win[1] ? ST_BUSY1 : ST_BUSY0;
        grant_d = win;
        last_d  = win[1];
        wdog_d  = '0;
      end
    end else if (busy) begin
      if (!mv) begin
        state_d = ST_IDLE;
        grant_d = '0;
      end else if (s.ready || wdog_q == WDOG_W'(TIMEOUT - 1)) begin
        state_d  = ST_DONE;
        ready_d  = {sel, ~sel};
        terr_d   = ~s.ready;
        rdata0_d = sel ? rdata0_q : rsp;
        rdata1_d = sel ? rsp : rdata1_q;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end else begin
      state_d = ST_IDLE;
      grant_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      ready_q  <= '0;
      last_q   <= 1'b1;
      terr_q   <= 1'b0;
      wdog_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ready_q  <= ready_d;
      last_q   <= last_d;
      terr_q   <= terr_d;
      wdog_q   <= wdog_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
  assign m0.ready    = ready_q[0];
  assign m0.rdata    = rdata0_q;
  assign m1.ready    = ready_q[1];
  assign m1.rdata    = rdata1_q;
  assign grant       = grant_q;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: round-robin (g[0]) and fixed-priority (g[1]) arbiters against a transaction-level RAM model
module tb_mem_bus_arbiter;
  typedef struct {
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  s;
  } req_t;
  typedef struct {
    int          n;
    logic [31:0] rd;
  } cmp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset [2];
  logic [1:0]  grant [2];
  logic        terr [2];
  logic        mvalid [4];
  logic [31:0] maddr [4];
  logic [31:0] mwdata [4];
  logic [3:0]  mwstrb [4];
  logic        mready [4];
  logic [31:0] mrdata [4];
  logic        svalid [2];
  logic [31:0] saddr [2];
  logic [31:0] swdata [2];
  logic [3:0]  sstrb [2];
  logic        sready [2];
  logic [31:0] srdata [2];
  logic [31:0] smem [2][2048];
  logic [31:0] mm [2][2048];
  int lat [2], scnt [2], slat [2], tcnt [2], mlast [2], rcnt [4];
  req_t rq [4][$];
  cmp_t cq [2][$];
  cmp_t expq [2][$];
  int checks = 0;
  int errs = 0;
  for (genvar d = 0; d < 2; d++) begin : g
    mem_bus_arbiter_if im0 ();
    mem_bus_arbiter_if im1 ();
    mem_bus_arbiter_if is ();
    assign im0.valid = mvalid[2*d];
    assign im0.addr = maddr[2*d];
    assign im0.wdata = mwdata[2*d];
    assign im0.wstrb = mwstrb[2*d];
    assign im1.valid = mvalid[2*d+1];
    assign im1.addr = maddr[2*d+1];
    assign im1.wdata = mwdata[2*d+1];
    assign im1.wstrb = mwstrb[2*d+1];
    assign mready[2*d] = im0.ready;
    assign mrdata[2*d] = im0.rdata;
    assign mready[2*d+1] = im1.ready;
    assign mrdata[2*d+1] = im1.rdata;
    assign is.ready = sready[d];
    assign is.rdata = srdata[d];
    assign svalid[d] = is.valid;
    assign saddr[d] = is.addr;
    assign swdata[d] = is.wdata;
    assign sstrb[d] = is.wstrb;
    mem_bus_arbiter #(.PRIORITY_MODE(d), .TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
      .clk         (clk),
      .reset       (reset[d]),
      .m0          (im0),
      .m1          (im1),
      .s           (is),
      .grant       (grant[d]),
      .timeout_err (terr[d])
    );
  end
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] model_acc(int d, req_t r);
    logic [10:0] i;
    logic [31:0] old;
    i = r.a[12:2];
    old = mm[d][i];
    for (int b = 0; b < 4; b++) if (r.s[b]) mm[d][i][8*b +: 8] = r.w[8*b +: 8];
    return old;
  endfunction
  function automatic req_t rnd_req();
    req_t r;
    r.a = (($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'h0) | (32'($urandom_range(64, 2047)) << 2);
    r.w = $urandom;
    r.s = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
    return r;
  endfunction
  function automatic req_t mk(logic [31:0] a, logic [31:0] w, logic [3:0] s);
    req_t r;
    r.a = a;
    r.w = w;
    r.s = s;
    return r;
  endfunction
  task automatic cyc();
    logic [10:0] ix;
    cmp_t c;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("both_ready", 32'(mready[2*d] & mready[2*d+1]), 0);
      if (terr[d]) tcnt[d]++;
      for (int n = 0; n < 2; n++) begin
        int k;
        k = 2*d + n;
        if (mready[k]) begin
          rcnt[k]++;
          check("ready_owner", 32'(grant[d]), (n == 1) ? 2 : 1);
          check("ready_has_valid", 32'(mvalid[k]), 1);
          if (mvalid[k]) begin
            c.n = n;
            c.rd = mrdata[k];
            cq[d].push_back(c);
            void'(rq[k].pop_front());
            mvalid[k] = 1'b0;
          end
        end
        if (!mvalid[k] && rq[k].size() > 0) begin
          mvalid[k] = 1'b1;
          maddr[k] = rq[k][0].a;
          mwdata[k] = rq[k][0].w;
          mwstrb[k] = rq[k][0].s;
        end
      end
      if (svalid[d]) begin
        scnt[d]++;
        if (scnt[d] == 1) slat[d] = (lat[d] < 0) ? int'($urandom_range(1, 5)) : lat[d];
        if (slat[d] != 0 && scnt[d] == slat[d]) begin
          ix = saddr[d][12:2];
          sready[d] = 1'b1;
          srdata[d] = smem[d][ix];
          for (int b = 0; b < 4; b++) if (sstrb[d][b]) smem[d][ix][8*b +: 8] = swdata[d][8*b +: 8];
        end else begin
          sready[d] = 1'b0;
          srdata[d] = $urandom;
        end
      end else begin
        scnt[d] = 0;
        sready[d] = 1'b0;
        srdata[d] = $urandom;
      end
    end
  endtask
  task automatic chk_zero(int d);
    check("rst_m0_ready", 32'(mready[2*d]), 0);
    check("rst_m0_rdata", mrdata[2*d], 0);
    check("rst_m1_ready", 32'(mready[2*d+1]), 0);
    check("rst_m1_rdata", mrdata[2*d+1], 0);
    check("rst_s_valid", 32'(svalid[d]), 0);
    check("rst_s_addr", saddr[d], 0);
    check("rst_s_wdata", swdata[d], 0);
    check("rst_s_wstrb", 32'(sstrb[d]), 0);
    check("rst_grant", 32'(grant[d]), 0);
    check("rst_timeout_err", 32'(terr[d]), 0);
  endtask
  task automatic push_batch(int d, int c0, int c1);
    req_t lst [2][$];
    req_t r;
    cmp_t e;
    int a0, a1, w;
    cq[d].delete();
    expq[d].delete();
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < ((n == 1) ? c1 : c0); i++) begin
        r = rnd_req();
        lst[n].push_back(r);
        rq[2*d+n].push_back(r);
      end
    a0 = c0;
    a1 = c1;
    while (a0 + a1 > 0) begin
      w = (a0 > 0 && a1 > 0) ? ((d == 1) ? 0 : 1 - mlast[d]) : ((a0 > 0) ? 0 : 1);
      mlast[d] = w;
      r = lst[w].pop_front();
      e.n = w;
      e.rd = model_acc(d, r);
      expq[d].push_back(e);
      if (w == 1) a1--; else a0--;
    end
  endtask
  task automatic drain(int d);
    cmp_t e, o;
    int b;
    b = 0;
    while (cq[d].size() < expq[d].size() && b < 3000) begin
      cyc();
      b++;
    end
    check("drain_count", cq[d].size(), expq[d].size());
    while (expq[d].size() > 0 && cq[d].size() > 0) begin
      e = expq[d].pop_front();
      o = cq[d].pop_front();
      check("order_master", o.n, e.n);
      check("order_rdata", o.rd, e.rd);
    end
  endtask
  task automatic wait_grant(int d);
    int b;
    b = 0;
    while (grant[d] == 2'b00 && b < 50) begin
      cyc();
      b++;
    end
  endtask
  task automatic wait_ready(int k, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!mready[k] && n < 60);
  endtask
  initial begin
    #2000000;
    $fatal(1, "FAIL global_timeout");
  end
  initial begin
    int k, t0, r0;
    logic [31:0] ev;
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1;
      sready[d] = 1'b0;
      srdata[d] = '0;
      lat[d] = -1;
      scnt[d] = 0;
      slat[d] = 0;
      tcnt[d] = 0;
      mlast[d] = 1;
      for (int i = 0; i < 2048; i++) begin
        smem[d][i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        mm[d][i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
      end
      smem[d][4] = 32'h1234_5678;
      mm[d][4] = 32'h1234_5678;
    end
    for (int k2 = 0; k2 < 4; k2++) begin
      mvalid[k2] = 1'b0;
      maddr[k2] = '0;
      mwdata[k2] = '0;
      mwstrb[k2] = '0;
      rcnt[k2] = 0;
    end
    repeat (3) cyc();
    chk_zero(0);
    chk_zero(1);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    cyc();
    push_batch(0, 4, 4);
    push_batch(1, 4, 4);
    drain(0);
    drain(1);
    lat[0] = 1;
    rq[0].push_back(mk(32'h0000_0010, 32'h0, 4'h0));
    wait_grant(0);
    check("t1_grant", 32'(grant[0]), 1);
    check("t1_s_valid", 32'(svalid[0]), 1);
    check("t1_s_addr", saddr[0], 32'h0000_0010);
    wait_ready(0, k);
    check("t1_latency", k, 1);
    check("t1_rdata", mrdata[0], 32'h1234_5678);
    check("t1_grant_done", 32'(grant[0]), 1);
    check("t1_m1_quiet", 32'(mready[1]), 0);
    cyc();
    check("t1_ready_pulse", 32'(mready[0]), 0);
    check("t1_grant_idle", 32'(grant[0]), 0);
    check("t1_rdata_hold", mrdata[0], 32'h1234_5678);
    mlast[0] = 0;
    cq[0].delete();
    lat[0] = 0;
    t0 = tcnt[0];
    rq[1].push_back(mk(32'h8000_0004, 32'h0000_0041, 4'b0001));
    wait_grant(0);
    check("t4_grant", 32'(grant[0]), 2);
    check("t4_s_addr", saddr[0], 32'h8000_0004);
    check("t4_s_wdata", swdata[0], 32'h0000_0041);
    check("t4_s_wstrb", 32'(sstrb[0]), 1);
    rq[0].push_back(mk(32'h0000_0200, 32'h0, 4'h0));
    wait_ready(1, k);
    check("t4_wait_cycles", k, 16);
    check("t4_rdata", mrdata[1], 32'hDEAD_BEEF);
    check("t4_timeout_err", 32'(terr[0]), 1);
    check("t4_s_valid_low", 32'(svalid[0]), 0);
    check("t4_m0_waiting", 32'(mready[0]), 0);
    lat[0] = 2;
    cyc();
    check("t4_err_pulse", 32'(terr[0]), 0);
    check("t4_ready_pulse", 32'(mready[1]), 0);
    wait_grant(0);
    check("t4_m0_grant", 32'(grant[0]), 1);
    ev = model_acc(0, mk(32'h0000_0200, 32'h0, 4'h0));
    wait_ready(0, k);
    check("t4_m0_latency", k, 2);
    check("t4_m0_rdata", mrdata[0], ev);
    check("t4_err_count", tcnt[0] - t0, 1);
    mlast[0] = 0;
    cq[0].delete();
    cyc();
    lat[0] = 16;
    t0 = tcnt[0];
    rq[1].push_back(mk(32'h0000_0300, 32'h0, 4'h0));
    ev = model_acc(0, mk(32'h0000_0300, 32'h0, 4'h0));
    wait_grant(0);
    check("t5_grant", 32'(grant[0]), 2);
    wait_ready(1, k);
    check("t5_wait_cycles", k, 16);
    check("t5_rdata", mrdata[1], ev);
    check("t5_timeout_err", 32'(terr[0]), 0);
    cyc();
    check("t5_err_count", tcnt[0] - t0, 0);
    mlast[0] = 1;
    cq[0].delete();
    lat[0] = -1;
    for (int r = 0; r < 4; r++) begin
      push_batch(0, $urandom_range(0, 6), $urandom_range(1, 6));
      push_batch(1, $urandom_range(1, 6), $urandom_range(0, 6));
      drain(0);
      drain(1);
      cyc();
    end
    lat[0] = 0;
    rq[0].push_back(mk(32'h0000_0400, 32'h0, 4'h0));
    wait_grant(0);
    check("t6_grant", 32'(grant[0]), 1);
    repeat (3) cyc();
    r0 = rcnt[0];
    reset[0] = 1'b1;
    rq[0].delete();
    mvalid[0] = 1'b0;
    cyc();
    chk_zero(0);
    reset[0] = 1'b0;
    mlast[0] = 1;
    lat[0] = 1;
    cq[0].delete();
    rq[1].push_back(mk(32'h0000_0404, 32'h0, 4'h0));
    ev = model_acc(0, mk(32'h0000_0404, 32'h0, 4'h0));
    wait_grant(0);
    check("t6_m1_grant", 32'(grant[0]), 2);
    wait_ready(1, k);
    check("t6_m1_latency", k, 1);
    check("t6_m1_rdata", mrdata[1], ev);
    repeat (3) cyc();
    check("t6_no_m0_ready", rcnt[0], r0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
